// File: rtl/demux_1to8_8bit_reg.sv
// Registered 1-to-8 demultiplexer: steers one handshaked input word into one of
// eight single-entry holding registers, each drained by its own consumer handshake.
module demux_1to8_8bit_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [2:0]           in_sel,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [3:0]           occ
);

    logic [WIDTH-1:0] r_data [NCH];
    logic [NCH-1:0]   r_valid;
    logic [3:0]       r_occ;

    logic             w_write;
    logic [NCH-1:0]   w_valid_nxt;
    logic [3:0]       w_occ_nxt;

    // A full channel being drained this cycle may be refilled in the same cycle.
    assign in_ready = ~clr & (~r_valid[in_sel] | out_ready[in_sel]);
    assign w_write  = in_valid & in_ready;

    always_comb begin
        w_valid_nxt = r_valid;
        w_occ_nxt   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (clr) begin
                w_valid_nxt[k] = 1'b0;
            end else if (w_write && (in_sel == 3'(k))) begin
                w_valid_nxt[k] = 1'b1;
            end else if (r_valid[k] && out_ready[k]) begin
                w_valid_nxt[k] = 1'b0;
            end
            w_occ_nxt = w_occ_nxt + 4'(w_valid_nxt[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            for (int unsigned k = 0; k < NCH; k++) begin
                if (w_write && (in_sel == 3'(k))) begin
                    r_data[k] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            out_data[k*WIDTH +: WIDTH] = r_data[k];
        end
    end

    assign out_valid = r_valid;
    assign occ       = r_occ;

endmodule

// File: tb/tb_demux_1to8_8bit_reg.sv
// Directed bench for demux_1to8_8bit_reg with hand-computed expectations.
module tb_demux_1to8_8bit_reg;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [63:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [3:0]  occ;

    int vectors;
    int miscompares;

    demux_1to8_8bit_reg #(.WIDTH(8), .NCH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid === 1'b1) begin
            assert (!$isunknown(in_sel)) else begin
                miscompares++;
                $error("FAIL in_sel_known: observed %b required known", in_sel);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 3'd0;
        out_ready = 8'h00;

        // Reset then idle
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'h00);
        check("reset_occ", 64'(occ), 64'd0);
        check("reset_out_data", out_data, 64'h0);
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            check($sformatf("idle_in_ready_sel%0d", s), 64'(in_ready), 64'd1);
        end
        tick();

        // Single write, then stalled second write released by out_ready
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 3'd3;
        #1;
        check("wr1_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_data = 8'h5A;
        #1;
        check("wr1_out_valid", 64'(out_valid), 64'h08);
        check("wr1_ch3", 64'(out_data[31:24]), 64'hA5);
        check("wr1_occ", 64'(occ), 64'd1);
        check("wr2_blocked", 64'(in_ready), 64'd0);
        tick();
        check("wr2_held_valid", 64'(out_valid), 64'h08);
        check("wr2_held_ch3", 64'(out_data[31:24]), 64'hA5);
        out_ready = 8'h08;
        #1;
        check("wr2_refill_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; out_ready = 8'h00;
        check("wr2_out_valid", 64'(out_valid), 64'h08);
        check("wr2_ch3", 64'(out_data[31:24]), 64'h5A);
        check("wr2_occ", 64'(occ), 64'd1);

        // Drain channel 3; data is kept
        out_ready = 8'h08;
        tick();
        out_ready = 8'h00;
        check("drain3_out_valid", 64'(out_valid), 64'h00);
        check("drain3_ch3_kept", 64'(out_data[31:24]), 64'h5A);
        check("drain3_occ", 64'(occ), 64'd0);

        // Fill all channels
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_sel = 3'(k); in_data = 8'(8'h10 + k);
            tick();
        end
        in_valid = 1'b0;
        check("fill_out_valid", 64'(out_valid), 64'hFF);
        check("fill_occ", 64'(occ), 64'd8);
        check("fill_data", out_data, 64'h1716151413121110);
        in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h99;
        #1;
        check("ninth_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        check("ninth_ch0_kept", 64'(out_data[7:0]), 64'h10);
        check("ninth_occ", 64'(occ), 64'd8);

        // Multi-drain
        out_ready = 8'b1010_1010;
        tick();
        out_ready = 8'h00;
        check("mdrain_out_valid", 64'(out_valid), 64'h55);
        check("mdrain_occ", 64'(occ), 64'd4);
        check("mdrain_data", out_data, 64'h1716151413121110);

        // clr vs write
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr1_out_valid", 64'(out_valid), 64'h00);
        in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h21;
        tick();
        in_sel = 3'd6; in_data = 8'h26;
        tick();
        in_valid = 1'b0;
        check("ch16_out_valid", 64'(out_valid), 64'h42);
        check("ch16_occ", 64'(occ), 64'd2);
        clr = 1'b1; in_valid = 1'b1; in_sel = 3'd2; in_data = 8'hEE;
        #1;
        check("clr_in_ready", 64'(in_ready), 64'd0);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_out_valid", 64'(out_valid), 64'h00);
        check("clr_occ", 64'(occ), 64'd0);
        check("clr_ch2_not_loaded", 64'(out_data[23:16]), 64'h12);
        check("clr_ch1_kept", 64'(out_data[15:8]), 64'h21);

        // Async reset mid-stream
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = 3'(k); in_data = 8'(8'h30 + k);
            out_ready = 8'($urandom);
            tick();
        end
        out_ready = 8'h00;
        in_sel = 3'd4; in_data = 8'h34;
        check("stream_ch3_valid", 64'(out_valid[3]), 64'd1);
        check("stream_ch3_data", 64'(out_data[31:24]), 64'h33);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'h00);
        check("async_rst_occ", 64'(occ), 64'd0);
        check("async_rst_data", out_data, 64'h0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_edge_no_write", 64'(out_valid), 64'h00);
        in_valid = 1'b1; in_sel = 3'd5; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        check("post_rst_out_valid", 64'(out_valid), 64'h20);
        check("post_rst_ch5", 64'(out_data[47:40]), 64'hC3);
        check("post_rst_occ", 64'(occ), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
